// File: rtl/avalon_pio_pkg.sv
// Shared definitions for the multi-channel Avalon PIO: register offsets
// relative to the channel count, CTRL bit positions and the arm-counter limit.
package avalon_pio_pkg;

  localparam int CTRL_AUTO   = 0;
  localparam int CTRL_COMMIT = 1;
  localparam int CTRL_PEND   = 2;

  // Edge capture stays disarmed until the arm counter reaches this value.
  localparam logic [1:0] ARM_LAST = 2'd3;

  function automatic int OFS_CTRL(input int n);
    return n;
  endfunction

  function automatic int OFS_EDGE(input int n);
    return n + 1;
  endfunction

  function automatic int OFS_MASK(input int n);
    return n + 2;
  endfunction

endpackage

// File: rtl/pio_edge_capture.sv
// Input sensing for the PIO: synchronises the external inputs and detects
// rising edges. Edges are captured into a W1C register and gated by a mask
// to form a registered level interrupt.
module pio_edge_capture
  import avalon_pio_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic             clr_we,
  input  logic [WIDTH-1:0] clr_mask,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_d,
  output logic [WIDTH-1:0] edge_q,
  output logic [WIDTH-1:0] mask_q,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [1:0]       arm_cnt_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr_bits;

  // Two-flop synchroniser followed by the previous-value flop for edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Arm counter keeps inputs already high at reset release from looking like edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_cnt_q <= 2'd0;
    end else if (arm_cnt_q != ARM_LAST) begin
      arm_cnt_q <= arm_cnt_q + 2'd1;
    end
  end

  // Qualified rising edges and the bits a W1C write asks to clear.
  always_comb begin
    rise     = '0;
    clr_bits = '0;
    if (arm_cnt_q == ARM_LAST) begin
      rise = sync2_q & ~prev_q;
    end
    if (clr_we) begin
      clr_bits = clr_mask;
    end
  end

  // Edge register: clear first, then OR in new edges so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~clr_bits) | rise;
    end
  end

  // Interrupt enable mask, plain read/write register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
    end else if (mask_we) begin
      mask_q <= mask_d;
    end
  end

  // Registered level interrupt from any enabled captured edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_q & mask_q);
    end
  end

endmodule

// File: rtl/avalon_pio_multi.sv
// Multi-channel Avalon-MM PIO. Output channels are double-buffered so the CPU
// can stage several channels and make them live together with a commit, or run
// in AUTO mode where each data write goes straight through. One input port
// with edge capture and a maskable interrupt is included.
module avalon_pio_multi
  import avalon_pio_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  input  logic [WIDTH-1:0]        in_port,
  output logic [NUM_CH*WIDTH-1:0] out_port,
  output logic                    irq
);

  localparam logic [ADDR_W-1:0] ADDR_CTRL = ADDR_W'(OFS_CTRL(NUM_CH));
  localparam logic [ADDR_W-1:0] ADDR_EDGE = ADDR_W'(OFS_EDGE(NUM_CH));
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(OFS_MASK(NUM_CH));

  logic                    wr;
  logic                    ctrl_we;
  logic                    edge_we;
  logic                    mask_we;
  logic                    commit;
  logic                    auto_q;
  logic                    pend;
  logic [NUM_CH-1:0]       ch_diff;
  logic [NUM_CH*WIDTH-1:0] shadow_flat;
  logic [WIDTH-1:0]        edge_q;
  logic [WIDTH-1:0]        mask_q;
  logic                    unused_bits;

  assign wr      = chipselect & ~write_n;
  assign ctrl_we = wr && (address == ADDR_CTRL);
  assign edge_we = wr && (address == ADDR_EDGE);
  assign mask_we = wr && (address == ADDR_MASK);

  // A commit only has meaning while staging; in AUTO mode live already follows.
  assign commit  = ctrl_we & writedata[CTRL_COMMIT] & ~auto_q;
  assign pend    = |ch_diff;

  // Upper writedata bits beyond the channel width carry no meaning here.
  assign unused_bits = ^writedata;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] shadow_q;
    logic [WIDTH-1:0] live_q;
    logic             data_we;

    assign data_we = wr && (address == ADDR_W'(i));

    // Shadow takes every data write; live follows in AUTO mode or on commit.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shadow_q <= '0;
        live_q   <= '0;
      end else if (data_we) begin
        shadow_q <= writedata[WIDTH-1:0];
        if (auto_q) begin
          live_q <= writedata[WIDTH-1:0];
        end
      end else if (commit) begin
        live_q <= shadow_q;
      end
    end

    assign shadow_flat[i*WIDTH +: WIDTH] = shadow_q;
    assign out_port[i*WIDTH +: WIDTH]    = live_q;
    assign ch_diff[i]                    = (shadow_q != live_q);
  end

  // AUTO mode bit; turning it on does not touch live until the next update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      auto_q <= 1'b0;
    end else if (ctrl_we) begin
      auto_q <= writedata[CTRL_AUTO];
    end
  end

  pio_edge_capture #(
    .WIDTH(WIDTH)
  ) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .clr_we  (edge_we),
    .clr_mask(writedata[WIDTH-1:0]),
    .mask_we (mask_we),
    .mask_d  (writedata[WIDTH-1:0]),
    .edge_q  (edge_q),
    .mask_q  (mask_q),
    .irq     (irq)
  );

  // Zero-latency read mux; unmapped offsets and unused upper bits read 0.
  always_comb begin
    readdata = '0;
    if (address == ADDR_CTRL) begin
      readdata[CTRL_AUTO] = auto_q;
      readdata[CTRL_PEND] = pend;
    end else if (address == ADDR_EDGE) begin
      readdata = 32'(edge_q);
    end else if (address == ADDR_MASK) begin
      readdata = 32'(mask_q);
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (address == ADDR_W'(i)) begin
          readdata = 32'(shadow_flat[i*WIDTH +: WIDTH]);
        end
      end
    end
  end

endmodule

// File: tb/tb_avalon_pio_multi.sv
// Self-checking bench for avalon_pio_multi: directed register-map scenarios with
// literal expectations, then randomized bus/input traffic compared every cycle
// against a register-level behavioural model of the PIO.
module tb_avalon_pio_multi;

  localparam int NUM_CH = 2;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;

  logic                    clk        = 1'b0;
  logic                    reset_n    = 1'b1;
  logic [ADDR_W-1:0]       address    = '0;
  logic                    chipselect = 1'b0;
  logic                    write_n    = 1'b1;
  logic [31:0]             writedata  = '0;
  logic [31:0]             readdata;
  logic [WIDTH-1:0]        in_port    = '0;
  logic [NUM_CH*WIDTH-1:0] out_port;
  logic                    irq;

  int total    = 0;
  int bad      = 0;
  bit check_en = 1'b0;

  avalon_pio_multi #(
    .NUM_CH(NUM_CH),
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .irq       (irq)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_shadow [NUM_CH];
  logic [WIDTH-1:0] m_live   [NUM_CH];
  bit               m_auto;
  logic [WIDTH-1:0] m_edge;
  logic [WIDTH-1:0] m_mask;
  bit               m_irq;
  logic [WIDTH-1:0] m_hist [$];
  int               m_edges;
  logic [WIDTH-1:0] m_clr;
  logic [WIDTH-1:0] m_rise;
  bit               m_irq_next;
  int               m_addr;

  // Input value sampled k+1 clock edges ago; nothing sampled yet counts as 0.
  function automatic logic [WIDTH-1:0] hist_at(input int k);
    if (k < m_hist.size()) return m_hist[k];
    return '0;
  endfunction

  function automatic logic [NUM_CH*WIDTH-1:0] model_out();
    logic [NUM_CH*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) r[i*WIDTH +: WIDTH] = m_live[i];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int a);
    bit pend;
    pend = 1'b0;
    for (int i = 0; i < NUM_CH; i++) if (m_shadow[i] != m_live[i]) pend = 1'b1;
    if (a < NUM_CH)      return 32'(m_shadow[a]);
    if (a == NUM_CH)     return {29'd0, pend, 1'b0, m_auto};
    if (a == NUM_CH + 1) return 32'(m_edge);
    if (a == NUM_CH + 2) return 32'(m_mask);
    return 32'd0;
  endfunction

  // Model state advances on each clock edge; reset clears it immediately.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_shadow[i] = '0;
        m_live[i]   = '0;
      end
      m_auto  = 1'b0;
      m_edge  = '0;
      m_mask  = '0;
      m_irq   = 1'b0;
      m_hist.delete();
      m_edges = 0;
    end else begin
      m_irq_next = |(m_edge & m_mask);
      m_rise     = (m_edges >= 3) ? (hist_at(1) & ~hist_at(2)) : '0;
      m_clr      = '0;
      if (chipselect && !write_n) begin
        m_addr = int'(address);
        if (m_addr < NUM_CH) begin
          m_shadow[m_addr] = writedata[WIDTH-1:0];
          if (m_auto) m_live[m_addr] = writedata[WIDTH-1:0];
        end else if (m_addr == NUM_CH) begin
          if (writedata[1] && !m_auto) m_live = m_shadow;
          m_auto = writedata[0];
        end else if (m_addr == NUM_CH + 1) begin
          m_clr = writedata[WIDTH-1:0];
        end else if (m_addr == NUM_CH + 2) begin
          m_mask = writedata[WIDTH-1:0];
        end
      end
      m_edge = (m_edge & ~m_clr) | m_rise;
      m_irq  = m_irq_next;
      m_hist.push_front(in_port);
      if (m_hist.size() > 3) void'(m_hist.pop_back());
      if (m_edges < 3) m_edges++;
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, away from the active edge, compare DUT outputs with the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_out_port", 64'(out_port), 64'(model_out()));
      checkOutput("model_irq", 64'(irq), 64'(m_irq));
      checkOutput("model_readdata", 64'(readdata), 64'(model_read(int'(address))));
    end
  end

  // ---------------- stimulus ----------------
  // Drive one bus cycle just after a rising edge; it is sampled on the next edge.
  task automatic applyStimulus(input bit we, input int addr, input logic [31:0] data,
                               input logic [WIDTH-1:0] inp);
    int sel;
    @(posedge clk);
    #1;
    address   = ADDR_W'(addr);
    writedata = data;
    in_port   = inp;
    if (we) begin
      chipselect = 1'b1;
      write_n    = 1'b0;
    end else begin
      sel        = $urandom_range(0, 2);
      chipselect = (sel == 1);
      write_n    = (sel != 2);
    end
  endtask

  task automatic readCheck(input string name, input int addr, input logic [31:0] expected);
    applyStimulus(1'b0, addr, 32'd0, in_port);
    @(negedge clk);
    checkOutput(name, 64'(readdata), 64'(expected));
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #3 reset_n = 1'b0;
    #4 reset_n = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    #2 reset_n = 1'b0;
    check_en = 1'b1;
    in_port  = 16'h0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 reset_n = 1'b1;

    // Reset state: every offset reads 0 while in_port[0] is held high.
    for (int a = 0; a < 16; a++) readCheck($sformatf("reset_read%0d", a), a, 32'd0);
    checkOutput("reset_out_port", 64'(out_port), 64'd0);
    checkOutput("reset_irq", 64'(irq), 64'd0);
    readCheck("held_input_no_edge", 3, 32'd0);

    // Staged writes, then commit.
    applyStimulus(1'b1, 0, 32'h0000_1234, 16'h0001);
    applyStimulus(1'b1, 1, 32'h0000_ABCD, 16'h0001);
    readCheck("pend_before_commit", 2, 32'h4);
    checkOutput("out_before_commit", 64'(out_port), 64'd0);
    applyStimulus(1'b1, 2, 32'h2, 16'h0001);
    readCheck("ctrl_after_commit", 2, 32'h0);
    checkOutput("out_after_commit", 64'(out_port), 64'hABCD_1234);

    // AUTO mode write goes live on the same edge.
    applyStimulus(1'b1, 2, 32'h1, 16'h0001);
    applyStimulus(1'b1, 1, 32'h0000_0055, 16'h0001);
    readCheck("ctrl_auto", 2, 32'h1);
    checkOutput("out_auto", 64'(out_port), 64'h0055_1234);

    // Rising edge on in_port[3] lands in EDGE three cycles later.
    applyStimulus(1'b0, 3, 32'd0, 16'h0009);
    applyStimulus(1'b0, 3, 32'd0, 16'h0009);
    @(negedge clk);
    checkOutput("edge_cycle1", 64'(readdata), 64'd0);
    applyStimulus(1'b0, 3, 32'd0, 16'h0009);
    @(negedge clk);
    checkOutput("edge_cycle2", 64'(readdata), 64'd0);
    applyStimulus(1'b0, 3, 32'd0, 16'h0001);
    @(negedge clk);
    checkOutput("edge_cycle3", 64'(readdata), 64'h8);

    // Mask enables irq one cycle after the mask write.
    applyStimulus(1'b1, 4, 32'h8, 16'h0001);
    applyStimulus(1'b0, 4, 32'd0, 16'h0001);
    @(negedge clk);
    checkOutput("irq_mask_edge", 64'(irq), 64'd0);
    applyStimulus(1'b0, 4, 32'd0, 16'h0001);
    @(negedge clk);
    checkOutput("irq_asserted", 64'(irq), 64'd1);

    // W1C clears EDGE, irq drops one cycle later.
    applyStimulus(1'b1, 3, 32'h8, 16'h0001);
    applyStimulus(1'b0, 3, 32'd0, 16'h0001);
    @(negedge clk);
    checkOutput("edge_cleared", 64'(readdata), 64'd0);
    checkOutput("irq_lag", 64'(irq), 64'd1);
    applyStimulus(1'b0, 3, 32'd0, 16'h0001);
    @(negedge clk);
    checkOutput("irq_cleared", 64'(irq), 64'd0);

    // Re-capture, then clear in the very cycle a new rise arrives: set wins.
    repeat (4) applyStimulus(1'b0, 3, 32'd0, 16'h0009);
    readCheck("edge_recaptured", 3, 32'h8);
    repeat (3) applyStimulus(1'b0, 3, 32'd0, 16'h0001);
    applyStimulus(1'b0, 3, 32'd0, 16'h0009);
    applyStimulus(1'b0, 3, 32'd0, 16'h0009);
    applyStimulus(1'b1, 3, 32'h8, 16'h0009);
    applyStimulus(1'b0, 3, 32'd0, 16'h0009);
    @(negedge clk);
    checkOutput("set_wins_edge", 64'(readdata), 64'h8);
    applyStimulus(1'b0, 3, 32'd0, 16'h0009);
    @(negedge clk);
    checkOutput("set_wins_irq", 64'(irq), 64'd1);

    // Unmapped write is ignored.
    applyStimulus(1'b1, 7, 32'h0000_FFFF, 16'h0009);
    readCheck("unmapped_read", 7, 32'd0);
    checkOutput("unmapped_out", 64'(out_port), 64'h0055_1234);
    readCheck("unmapped_ctrl", 2, 32'h1);
    readCheck("unmapped_mask", 4, 32'h8);
    readCheck("unmapped_data0", 0, 32'h1234);
    readCheck("unmapped_data1", 1, 32'h55);
    readCheck("unmapped_edge", 3, 32'h8);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        pulseReset();
      end else begin
        applyStimulus(($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                                  : int'($urandom_range(0, NUM_CH + 2)),
                      $urandom,
                      ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : in_port);
      end
    end

    applyStimulus(1'b0, 0, 32'd0, in_port);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
